sp_mem_param: RTL
=================

// Module: sp_mem_param
// PURPOSE
//   Parametrised single-port synchronous RAM. Successor to the fixed 16x1024 bidirectional-bus memory.
//   - Separate write/read data buses, byte enables, request/ready handshake and read-valid flag.
//   - Post-reset hardware clear sequencer.
//   - Sits between fabric-side masters and local storage.
//   - One access (read or write) per cycle.
// PARAMETERS
//   DATA_W     16      data width in bits; multiple of 8
//   DEPTH      1024    number of words; need not be a power of 2, must be <= 2**ADDR_W
//   ADDR_W     10      address width in bits
//   INIT_VALUE 0       word value written to every location by the clear sequencer
// PORTS
//   clk     in   1         clock; all logic on rising edge
//   reset   in   1         asynchronous, active-high reset
//   req     in   1         access request; sampled only when ready=1
//   wr_en   in   1         1=write, 0=read; qualified by req
//   addr    in   ADDR_W    word address
//   wdata   in   DATA_W    write data
//   be      in   DATA_W/8  byte enables; be[i] covers wdata[8i+7:8i]
//   rdata   out  DATA_W    read data; valid when rvalid=1
//   rvalid  out  1         one-cycle pulse per accepted read
//   ready   out  1         1=requests accepted; 0 during clear sweep
//   err     out  1         one-cycle pulse: accepted request with addr >= DEPTH
// BEHAVIOUR
//   Reset values: rdata=0, rvalid=0, ready=0, err=0, FSM=CLEAR, clear pointer=0.
//   Array contents are not reset.
//   FSM states:
//     CLEAR: each cycle writes INIT_VALUE to mem[ptr], then ptr++.
//       ready=0; req is ignored.
//       On ptr==DEPTH-1 write, moves to RUN.
//       CLEAR therefore lasts exactly DEPTH cycles after reset deassertion.
//     RUN: ready=1; stays in RUN until reset.
//   Accept: a request is accepted on a rising edge where req=1 and ready=1 (RUN).
//   Write: on accept with wr_en=1, mem[addr] byte i <= wdata byte i for each be[i]=1.
//     Other bytes are unchanged. be=0 is a legal no-op write.
//   Read: on accept with wr_en=0, mem[addr] is sampled at that edge.
//     rdata is updated and rvalid=1 for one cycle at the next edge (latency 1).
//   Back-to-back: reads may issue every cycle; rvalid then stays high.
//     rdata updates each cycle in issue order.
//   Read-after-write: a read accepted the cycle after a write to the same address returns the new data.
//   rdata holds its last value while rvalid=0.
//   Out-of-range (addr >= DEPTH):
//     write: no array change.
//     read: rdata=0, rvalid=1 at normal latency.
//     both: err=1 for one cycle, aligned with the rvalid timing (next edge).
//   Reset mid-operation: asserting reset at any point returns the block to CLEAR with ptr=0.
//     Any in-flight rvalid is dropped. The full sweep restarts after deassertion.
// CONFIGURATION
//   SP_MEM_OUT_REG_EN defined:
//     extra output register on rdata/rvalid/err; read latency is 2 cycles.
//     Throughput is unchanged (one read per cycle).
//     Pipeline registers reset to 0.
//   SP_MEM_OUT_REG_EN undefined: read latency 1 cycle, as specified above.
// TESTING
//   1. Reset, DEPTH=1024:
//      -> ready=0 for exactly 1024 cycles after deassert, then 1.
//      -> read of addr 0x3FF returns INIT_VALUE with rvalid.
//   2. Full-word write 0xBEEF to addr 5, read addr 5 next cycle
//      -> rvalid=1 one cycle later (two with macro), rdata=0xBEEF.
//   3. Write 0x1234 to addr 7, then write 0xAB00 with be=2'b10, read addr 7
//      -> rdata=0xAB34.
//   4. DEPTH=1000, write 0x5555 to addr 1000, read addr 1000
//      -> err pulses twice, rdata=0, read addr 0 returns INIT_VALUE.
//   5. Four back-to-back reads of addrs 1..4 preloaded with 0x11..0x44
//      -> rvalid high 4 consecutive cycles, rdata=0x11,0x22,0x33,0x44 in order.
//   6. Assert reset at sweep ptr=500 and during a pending read
//      -> rvalid=0 immediately, ready=0, full 1024-cycle sweep repeats.

Source files
------------

// File: rtl/sp_mem_param_if.sv
// Request/response bus between a fabric-side master and sp_mem_param.
// Carries the access request, the byte-enabled write data, read data and status flags.
interface sp_mem_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic                  req;
  logic                  wr_en;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     rdata;
  logic                  rvalid;
  logic                  ready;
  logic                  err;

  modport master (
    output req, wr_en, addr, wdata, be,
    input  rdata, rvalid, ready, err
  );

  modport slave (
    input  req, wr_en, addr, wdata, be,
    output rdata, rvalid, ready, err
  );
endinterface

// File: rtl/sp_mem_param.sv
// Parametrised single-port RAM with byte enables, a post-reset clear sweep and a read-valid flag.
// Define SP_MEM_OUT_REG_EN to add an output register stage (read latency 2 instead of 1).
module sp_mem_param #(
  parameter int                 DATA_W     = 16,
  parameter int                 DEPTH      = 1024,
  parameter int                 ADDR_W     = 10,
  parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
  input  logic            clk,
  input  logic            reset,
  sp_mem_param_if.slave   bus
);

  localparam int                BE_W     = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   ptr, ptr_next;
  logic                clear_we;
  logic                ready_int;
  logic                accept;
  logic                in_range;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rdata_s1;
  logic                rvalid_s1;
  logic                err_s1;

  assign in_range = {1'b0, bus.addr} < DEPTH_L;
  assign accept   = bus.req & ready_int;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    clear_we   = 1'b0;
    ready_int  = 1'b0;
    case (state)
      CLEAR: begin
        clear_we = 1'b1;
        if (ptr == LAST_PTR) begin
          state_next = RUN;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr + 1'b1;
        end
      end
      RUN: ready_int = 1'b1;
      default: state_next = CLEAR;
    endcase
  end

  // Storage is never reset; the clear sweep is what gives it a known value.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[ptr] <= INIT_VALUE;
    end else if (accept && bus.wr_en && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.be[i]) mem[bus.addr][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_s1  <= '0;
      rvalid_s1 <= 1'b0;
      err_s1    <= 1'b0;
    end else begin
      rvalid_s1 <= accept & ~bus.wr_en;
      err_s1    <= accept & ~in_range;
      if (accept && !bus.wr_en) rdata_s1 <= in_range ? mem[bus.addr] : '0;
    end
  end

  assign bus.ready = ready_int;

`ifdef SP_MEM_OUT_REG_EN
  logic [DATA_W-1:0] rdata_s2;
  logic              rvalid_s2;
  logic              err_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_s2  <= '0;
      rvalid_s2 <= 1'b0;
      err_s2    <= 1'b0;
    end else begin
      rdata_s2  <= rdata_s1;
      rvalid_s2 <= rvalid_s1;
      err_s2    <= err_s1;
    end
  end

  assign bus.rdata  = rdata_s2;
  assign bus.rvalid = rvalid_s2;
  assign bus.err    = err_s2;
`else
  assign bus.rdata  = rdata_s1;
  assign bus.rvalid = rvalid_s1;
  assign bus.err    = err_s1;
`endif

endmodule
